// File: rtl/aes_round_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_engine_if
// Description : Block handshake bundle between the AES round engine and its
//               producer/consumer (plaintext/key in, round-9 state/K10 out).
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [127:0] key_last;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, state_out, key_last
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, state_out, key_last
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_engine
// Description : Iterative AES-128 initial AddRoundKey + rounds 1..9, one round
//               per clock, key schedule expanded on the fly up to K10.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_engine (
    input  wire logic          clk,
    input  wire logic          rst_n,
    aes_round_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_KEYX  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] pw;
        inv = 8'h01;
        pw  = a;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sub_byte(rk[23:16]) ^ rcon, sub_byte(rk[15:8]),
              sub_byte(rk[7:0]), sub_byte(rk[31:24])};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64]  ^ n0;
        n2 = rk[63:32]  ^ n1;
        n3 = rk[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t       r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [127:0] r_st;
    logic [127:0] r_rk;
    logic [3:0]   r_rnd;

    logic [7:0]   w_rcon;
    logic [127:0] w_next_key;
    logic [127:0] w_sub_shift;
    logic [127:0] w_mixed;
    logic [127:0] w_next_st;

    // One key-schedule datapath serves both ROUND and KEYX; only Rcon differs.
    always_comb begin
        w_rcon = 8'h00;
        if (r_state == S_KEYX) begin
            w_rcon = 8'h36;
        end else begin
            case (r_rnd)
                4'd1:    w_rcon = 8'h01;
                4'd2:    w_rcon = 8'h02;
                4'd3:    w_rcon = 8'h04;
                4'd4:    w_rcon = 8'h08;
                4'd5:    w_rcon = 8'h10;
                4'd6:    w_rcon = 8'h20;
                4'd7:    w_rcon = 8'h40;
                4'd8:    w_rcon = 8'h80;
                4'd9:    w_rcon = 8'h1b;
                default: w_rcon = 8'h00;
            endcase
        end
    end

    assign w_next_key = expand(r_rk, w_rcon);

    // Output byte s(r,c) takes SubBytes of input s(r,(c+r) mod 4).
    for (genvar n = 0; n < 16; n++) begin : g_sbox
        localparam int c_src = 4 * (((n / 4) + (n % 4)) % 4) + (n % 4);
        assign w_sub_shift[127-8*n -: 8] = sub_byte(r_st[127-8*c_src -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign w_mixed[127-32*c -: 32] = mix_col(w_sub_shift[127-32*c -: 32]);
    end

    assign w_next_st = w_mixed ^ w_next_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_st        <= '0;
            r_rk        <= '0;
            r_rnd       <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_st       <= bus.plaintext ^ bus.key;
                        r_rk       <= bus.key;
                        r_rnd      <= 4'd1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_st  <= w_next_st;
                    r_rk  <= w_next_key;
                    r_rnd <= r_rnd + 4'd1;
                    if (r_rnd == 4'd9) r_state <= S_KEYX;
                end
                S_KEYX: begin
                    r_rk        <= w_next_key;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.state_out = r_st;
    assign bus.key_last  = r_rk;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_engine
// Description : Scoreboard bench for aes_round_engine with an AES reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_round_engine_if bus ();

    aes_round_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [127:0] st;
        logic [127:0] k;
        logic         has_st;
        logic [127:0] st_fips;
        logic         has_kc;
        logic [127:0] k_fips;
        logic [127:0] ct_fips;
        int           acc;
    } exp_t;

    exp_t       q[$];
    int         hs_cyc[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] sbox [256];

    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_KL = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_ST  = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] B_KL  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Carry-less multiply then reduce modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] o;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            o = 8'h63;
            for (int i = 0; i < 8; i++)
                o[i] = o[i] ^ inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox[x] = o;
        end
    endfunction

    // Returns {state after round 9, round key 10}.
    function automatic logic [255:0] model(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] st9;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ k[127-8*n -: 8];
        for (int r = 1; r <= 9; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sbox[s[n]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*((c+rw)%4)+rw];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++)
                    t[4*c+i] = gm(8'h02, s[4*c+i]) ^ gm(8'h03, s[4*c+(i+1)%4])
                             ^ s[4*c+(i+2)%4] ^ s[4*c+(i+3)%4];
            for (int n = 0; n < 16; n++) s[n] = t[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) st9[127-8*n -: 8] = s[n];
        return {st9, w[40], w[41], w[42], w[43]};
    endfunction

    function automatic logic [127:0] last_round(input logic [127:0] st, input logic [127:0] k);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                o[127-8*(4*c+rw) -: 8] = sbox[st[127-8*(4*((c+rw)%4)+rw) -: 8]];
        return o ^ k;
    endfunction

    // Monitor: pops the scoreboard on every handshake and polices hold/latency rules.
    logic         prev_ov = 1'b0;
    logic         prev_hs = 1'b0;
    logic [127:0] prev_st = '0;
    logic [127:0] prev_k  = '0;
    exp_t         e_mon;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) chk("out_valid_drop", 128'(bus.out_valid), 128'd0);
            if (bus.out_valid) begin
                chk("in_ready_while_done", 128'(bus.in_ready), 128'd0);
                if (!prev_ov) begin
                    if (q.size() == 0) chk("unexpected_result", 128'(q.size()), 128'd1);
                    else               chk("latency", 128'(cyc - q[0].acc), 128'd10);
                end else begin
                    chk("hold_state_out", bus.state_out, prev_st);
                    chk("hold_key_last", bus.key_last, prev_k);
                end
                if (bus.out_ready && q.size() != 0) begin
                    e_mon = q.pop_front();
                    hs_cyc.push_back(cyc + 1);
                    chk("state_out", bus.state_out, e_mon.st);
                    chk("key_last", bus.key_last, e_mon.k);
                    if (e_mon.has_st) chk("state_out_fips", bus.state_out, e_mon.st_fips);
                    if (e_mon.has_kc) begin
                        chk("key_last_fips", bus.key_last, e_mon.k_fips);
                        chk("ciphertext", last_round(bus.state_out, bus.key_last), e_mon.ct_fips);
                    end
                end
            end
            prev_ov = bus.out_valid;
            prev_hs = bus.out_valid && bus.out_ready;
            prev_st = bus.state_out;
            prev_k  = bus.key_last;
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] k,
                        input logic has_st, input logic [127:0] st_f,
                        input logic has_kc, input logic [127:0] k_f, input logic [127:0] ct_f);
        exp_t         e;
        logic [255:0] m;
        int           n;
        m = model(pt, k);
        e.st = m[255:128];  e.k = m[127:0];
        e.has_st = has_st;  e.st_fips = st_f;
        e.has_kc = has_kc;  e.k_fips = k_f;  e.ct_fips = ct_f;
        bus.in_valid = 1'b1; bus.plaintext = pt; bus.key = k;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            chk("accept_timeout", 128'(bus.in_ready), 128'd1);
            bus.in_valid = 1'b0;
        end else begin
            e.acc = cyc + 1;
            q.push_back(e);
            @(posedge clk); #1;
            bus.in_valid = 1'b0; bus.plaintext = rnd128(); bus.key = rnd128();
        end
    endtask

    task automatic drain(input logic bp);
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 128'(q.size()), 128'd0);
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        build_sbox();
        bus.in_valid = 1'b0; bus.plaintext = '0; bus.key = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset_in_ready", 128'(bus.in_ready), 128'd1);
        chk("reset_state_out", bus.state_out, 128'd0);
        chk("reset_key_last", bus.key_last, 128'd0);
        rst_n = 1'b1;

        bus.out_ready = 1'b1;
        send(C1_PT, C1_K, 1'b0, '0, 1'b1, C1_KL, C1_CT);
        drain(1'b0);
        send(B_PT, B_K, 1'b1, B_ST, 1'b1, B_KL, B_CT);
        drain(1'b0);

        // Backpressure: result must wait bit-stable in DONE.
        bus.out_ready = 1'b0;
        send(B_PT, B_K, 1'b1, B_ST, 1'b1, B_KL, B_CT);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
        chk("bp_pending", 128'(q.size()), 128'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
        chk("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
        chk("bp_release_queue", 128'(q.size()), 128'd0);

        // Busy-input rejection.
        send(rnd128(), rnd128(), 1'b0, '0, 1'b0, '0, '0);
        repeat (8) begin
            @(posedge clk); #1;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.plaintext = rnd128(); bus.key = rnd128();
            chk("busy_in_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.in_valid = 1'b0;
        drain(1'b0);

        // Asynchronous reset in the middle of round processing.
        bus.out_ready = 1'b1;
        send(C1_PT, C1_K, 1'b0, '0, 1'b1, C1_KL, C1_CT);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("mid_reset_state_out", bus.state_out, 128'd0);
        chk("mid_reset_key_last", bus.key_last, 128'd0);
        chk("mid_reset_out_valid", 128'(bus.out_valid), 128'd0);
        chk("mid_reset_in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_reset_no_output", 128'(bus.out_valid), 128'd0);
        send(C1_PT, C1_K, 1'b0, '0, 1'b1, C1_KL, C1_CT);
        drain(1'b0);

        // Back-to-back with out_ready held high.
        hs_cyc.delete();
        bus.out_ready = 1'b1;
        send(B_PT, B_K, 1'b1, B_ST, 1'b1, B_KL, B_CT);
        send(C1_PT, C1_K, 1'b0, '0, 1'b1, C1_KL, C1_CT);
        drain(1'b0);
        chk("b2b_count", 128'(hs_cyc.size()), 128'd2);
        if (hs_cyc.size() == 2) chk("b2b_spacing", 128'(hs_cyc[1] - hs_cyc[0]), 128'd12);

        // Randomised vectors with random consumer stalls.
        repeat (16) begin
            send(rnd128(), rnd128(), 1'b0, '0, 1'b0, '0, '0);
            drain(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative AES-128 encryption front end. It accepts a plaintext block and a cipher key through a valid/ready handshake and performs the initial AddRoundKey plus rounds 1–9, one round per clock, expanding the key schedule on the fly. It presents the round-9 state and round key 10 to the combinational `last_round` stage, which sits directly downstream and produces the ciphertext. The block holds one block in flight at a time.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — single clock; all flops on rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `in_valid`  in  1  — plaintext/key offered.
- `in_ready`  out  1  — engine idle, can accept a block.
- `plaintext`  in  128  — input block.
- `key`  in  128  — cipher key.
- `out_valid`  out  1  — `state_out`/`key_last` valid for `last_round`.
- `out_ready`  in  1  — downstream consumes the result.
- `state_out`  out  128  — state after round 9 (feeds `last_round.in`).
- `key_last`  out  128  — round key 10 (feeds `last_round.key_last`).

Byte order for all 128-bit buses:
- Bits [127:120] are FIPS-197 byte 0.
- Bytes are column-major: s(r,c) = byte 4c+r.

## Operation
FSM states are IDLE, ROUND, KEYX and DONE. A 4-bit round counter `rnd` steps through 1..9. Rcon is selected from `rnd` as 01, 02, 04, 08, 10, 20, 40, 80, 1B; the value 36 is used in KEYX.

- **IDLE.** `in_ready`=1.
  - When `in_valid&in_ready`: `st <= plaintext^key`, `rk <= key`, `rnd <= 1`, go to ROUND.
- **ROUND.** One round per cycle:
  - `nk = expand(rk, rcon(rnd))`: RotWord, SubWord, Rcon XOR into the first byte, then cascaded XOR of w0..w3.
  - `st <= MixColumns(ShiftRows(SubBytes(st))) ^ nk`.
  - `rk <= nk`, `rnd <= rnd+1`.
  - When `rnd==9`, go to KEYX.
- **KEYX.** `rk <= expand(rk, 36)` produces K10. `st` holds. Go to DONE.
- **DONE.** `out_valid`=1.
  - When `out_ready`, go to IDLE.
  - Otherwise `state_out` and `key_last` hold bit-stable.
- `state_out` = `st` and `key_last` = `rk`. Both are direct register outputs, with no combinational path from inputs.
- `in_valid` is ignored outside IDLE. Inputs are sampled only on the acceptance edge, so later changes to `plaintext`/`key` have no effect.
- Resources:
  - The round datapath uses 16 S-boxes for the state plus 4 for the key schedule. The existing `sub_byte` S-box logic may be reused.
  - MixColumns uses xtime with a 0x1B reduction, computed per byte in GF(2^8).
- **Reset.** Asserting `rst_n` low at any time, including mid-round, forces IDLE. `st`, `rk` and `rnd` clear to 0. Any in-flight block is discarded with no output.

## Timing
- Reset values:
  - `out_valid`=0.
  - `state_out`=0, `key_last`=0.
  - `in_ready`=1, decoded from IDLE. No transfer occurs while `rst_n` is low.
- Latency from the acceptance edge E0:
  - Rounds 1–9 complete on edges E1..E9.
  - K10 is formed on E10.
  - `out_valid` is high from E10 onward, i.e. 10 cycles after acceptance.
- Consumption and return to IDLE:
  - The output is consumed on the first edge where `out_valid&out_ready`. `out_valid` drops after that edge.
  - `in_ready` is 1 in the following cycle.
  - There is no same-cycle bypass, so the minimum period between accepted blocks is 12 cycles.
- `out_ready` may be held high in advance. DONE then lasts exactly one cycle.
- Downstream `last_round` is combinational. Ciphertext is valid whenever `out_valid`=1.

## Test plan
- **FIPS-197 App. C.1.** `plaintext` 00112233445566778899aabbccddeeff, `key` 000102030405060708090a0b0c0d0e0f.
  - Expect `out_valid` 10 cycles after acceptance.
  - `state_out`=7ad5fda789ef4e272bca100b3d9ff59f, `key_last`=13111d7fe3944a17f307a78b4d2b30c5.
  - `last_round` output = 69c4e0d86a7b0430d8cdb78070b4c55a.
- **FIPS-197 App. B.** `plaintext` 3243f6a8885a308d313198a2e0370734, `key` 2b7e151628aed2a6abf7158809cf4f3c.
  - Expect `state_out`=eb40f21e592e38848ba113e71bc342d2, `key_last`=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Ciphertext = 3925841d02dc09fbdc118597196a0b32.
- **Backpressure.** Run App. B with `out_ready`=0 for 20 cycles.
  - `out_valid` stays 1, outputs bit-stable, `in_ready`=0 throughout.
  - Raising `out_ready` for one cycle returns the engine to IDLE.
- **Busy-input rejection.** Toggle `in_valid` and change `plaintext`/`key` during ROUND.
  - Result is still the originally accepted vector. No second block is accepted until IDLE.
- **Reset mid-operation.** Pulse `rst_n` low asynchronously at round 5.
  - Outputs go to 0 immediately, `out_valid`=0, `in_ready`=1.
  - A subsequent App. C.1 run produces the correct result.
- **Back-to-back.** Hold `out_ready`=1 and present App. B then App. C.1 as soon as `in_ready` allows.
  - Two `out_valid` pulses of one cycle each, 12 cycles apart, with correct values in order.
